adc_sample_conditioner: RTL and testbench

- Sits between the MAX10 ADC block output (12-bit unsigned, PLL clock domain) and the effects pipeline input.
- Brings raw ADC codes into the 50 MHz system clock domain and rejects codes captured mid-transition.
- Decimates the free-running ADC stream to a fixed sample tick, then converts the code to signed 16-bit.
- Removes the DC bias with a first-order IIR blocker and emits one sample per tick with a single-cycle valid strobe.

---
 rtl/audio_pkg.sv | 20 ++
 rtl/dc_blocker.sv | 50 +++++
 rtl/adc_sample_conditioner.sv | 85 ++++++++
 tb/tb_adc_sample_conditioner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared sample types, ADC constants and the 17-to-16 bit saturation helper
// used by the ADC conditioning path.
package audio_pkg;

    localparam int ADC_W    = 12;
    localparam int SAMPLE_W = 16;

    localparam logic [ADC_W-1:0] ADC_MID = 12'h800;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Overflow into 17 bits shows up as the top two bits disagreeing.
    function automatic sample_t sat17to16(input logic signed [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? 16'sh8000 : 16'sh7fff;
        end
        return v[15:0];
    endfunction

endpackage

// File: rtl/dc_blocker.sv
// First-order IIR DC blocker with saturating output register; bypass freezes
// the DC estimate and passes the scaled sample through untouched.
module dc_blocker
    import audio_pkg::*;
#(
    parameter int DC_SHIFT = 10
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    input  logic    bypass,
    input  sample_t s,
    output sample_t y,
    output logic    y_valid,
    output logic    clip
);

    localparam int ACC_W = 17 + DC_SHIFT;

    logic signed [ACC_W-1:0] acc;
    logic signed [16:0]      dc;
    logic signed [16:0]      y_full;

    // The estimate stays well inside 17 bits, so truncating the shifted
    // accumulator loses nothing.
    assign dc     = 17'(acc >>> DC_SHIFT);
    assign y_full = 17'(s) - dc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            clip    <= 1'b0;
        end else begin
            y_valid <= in_valid;
            clip    <= 1'b0;
            if (in_valid) begin
                if (bypass) begin
                    y <= s;
                end else begin
                    y    <= sat17to16(y_full);
                    clip <= y_full[16] ^ y_full[15];
                    acc  <= acc + ACC_W'(y_full);
                end
            end
        end
    end

endmodule

// File: rtl/adc_sample_conditioner.sv
// Brings raw ADC codes into the system clock domain, decimates them to a
// fixed sample tick, converts to signed 16-bit and removes the DC bias.
module adc_sample_conditioner
    import audio_pkg::*;
#(
    parameter int CLK_MHZ  = 50,
    parameter int DIV      = 1042,
    parameter int DC_SHIFT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             bypass_dc,
    output sample_t          sample_out,
    output logic             sample_valid,
    output logic             clip
);

    if (DIV < 4 || DIV > 65535 || DC_SHIFT < 2 || DC_SHIFT > 15 || CLK_MHZ <= 0) begin : g_bad_param
        $error("adc_sample_conditioner: parameter out of range");
    end

    localparam logic [15:0] TICK_TC = 16'(DIV - 1);

    logic [ADC_W-1:0] sync1;
    logic [ADC_W-1:0] sync2;
    logic [ADC_W-1:0] sync3;
    logic [ADC_W-1:0] stable;
    logic [ADC_W-1:0] cap;
    logic [15:0]      tick_cnt;
    logic             tick;
    logic             cap_valid;
    sample_t          s;

    assign tick = (tick_cnt == TICK_TC);

    // A code is only trusted once it has survived two consecutive samples,
    // so a word caught mid-transition never reaches the capture register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            stable <= ADC_MID;
        end else begin
            sync1 <= adc_data;
            sync2 <= sync1;
            sync3 <= sync2;
            if (sync2 == sync3) begin
                stable <= sync2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            cap       <= '0;
            cap_valid <= 1'b0;
        end else begin
            tick_cnt  <= tick ? 16'd0 : tick_cnt + 16'd1;
            cap_valid <= tick;
            if (tick) begin
                cap <= stable;
            end
        end
    end

    // Subtracting mid-scale from a 12-bit code is just an MSB flip.
    assign s = {~cap[ADC_W-1], cap[ADC_W-2:0], 4'b0000};

    dc_blocker #(
        .DC_SHIFT (DC_SHIFT)
    ) u_dc_blocker (
        .clk      (clk),
        .rst      (rst),
        .in_valid (cap_valid),
        .bypass   (bypass_dc),
        .s        (s),
        .y        (sample_out),
        .y_valid  (sample_valid),
        .clip     (clip)
    );

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Bench for adc_sample_conditioner: directed scenarios plus randomized codes,
// all outputs compared each cycle against a behavioural model.
module tb_adc_sample_conditioner;

    localparam int DIV      = 8;
    localparam int DC_SHIFT = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [11:0]        adc_data = 12'h800;
    logic               bypass_dc = 1'b1;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               clip;

    int n_cmp = 0;
    int n_bad = 0;

    adc_sample_conditioner #(
        .CLK_MHZ  (50),
        .DIV      (DIV),
        .DC_SHIFT (DC_SHIFT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_data     (adc_data),
        .bypass_dc    (bypass_dc),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .clip         (clip)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Every clock edge since reset release records the ADC code present there.
    // The sample taken on a tick is the newest code seen on two consecutive
    // edges, old enough to have crossed the synchroniser; the reset contents
    // of the synchroniser count as code 0 before edge 0.
    int     a_q[$];
    longint acc_m;
    longint exp_out;
    bit     exp_valid;
    bit     exp_clip;

    function automatic int code_at(input int m);
        if (m < 0) return 0;
        return a_q[m];
    endfunction

    function automatic int captured(input int t);
        for (int m = t - 3; m >= -2; m--) begin
            if (code_at(m) == code_at(m - 1)) return code_at(m);
        end
        return 'h800;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            a_q.delete();
            acc_m     = 0;
            exp_out   = 0;
            exp_valid = 0;
            exp_clip  = 0;
        end else begin
            int n;
            a_q.push_back(int'(adc_data));
            n = a_q.size() - 1;
            exp_valid = 0;
            exp_clip  = 0;
            if (n >= 1 && ((n - 1) % DIV) == DIV - 1) begin
                longint s, dc, y;
                s = longint'(captured(n - 1) - 2048) * 16;
                exp_valid = 1;
                if (bypass_dc) begin
                    exp_out = s;
                end else begin
                    dc = acc_m >>> DC_SHIFT;
                    y  = s - dc;
                    acc_m = acc_m + y;
                    if (y > 32767) begin
                        exp_out = 32767;  exp_clip = 1;
                    end else if (y < -32768) begin
                        exp_out = -32768; exp_clip = 1;
                    end else begin
                        exp_out = y;
                    end
                end
            end
        end
        #1;
        check("sample_out", sample_out, exp_out);
        check("sample_valid", sample_valid, exp_valid);
        check("clip", clip, exp_clip);
    end

    // ---------------- stimulus helpers ----------------
    task automatic count_to_valid(input string name, output int k);
        bit seen = 0;
        k = 0;
        for (int i = 1; i <= 4 * DIV; i++) begin
            @(posedge clk); #1;
            if (sample_valid) begin
                k = i; seen = 1;
                break;
            end
        end
        check({name, "_timeout"}, seen, 1);
    endtask

    task automatic wait_valid(input string name, output longint v, output bit c);
        int k;
        count_to_valid(name, k);
        v = sample_out;
        c = clip;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        longint v, prev;
        bit c, mono_ok, clip_seen;
        int k;

        // 1: mid-scale, bypass, first pulse latency and spacing
        rst = 1; adc_data = 12'h800; bypass_dc = 1;
        repeat (3) @(negedge clk);
        #1 check("reset_out", sample_out, 0);
        check("reset_valid", sample_valid, 0);
        @(negedge clk); rst = 0;
        count_to_valid("t1_first", k);
        check("t1_first_latency", k, 9);
        check("t1_mid_value", sample_out, 0);
        count_to_valid("t1_second", k);
        check("t1_spacing", k, DIV);

        // 2: full-scale codes in bypass
        @(negedge clk); adc_data = 12'd4095;
        repeat (3) wait_valid("t2_hi", v, c);
        check("t2_full_pos", v, 32752);
        check("t2_full_pos_clip", c, 0);
        @(negedge clk); adc_data = 12'd0;
        repeat (3) wait_valid("t2_lo", v, c);
        check("t2_full_neg", v, -32768);
        check("t2_full_neg_clip", c, 0);

        // 3: DC step decays toward zero
        @(negedge clk); rst = 1; adc_data = 12'd3072; bypass_dc = 0;
        repeat (2) @(negedge clk); rst = 0;
        wait_valid("t3_s0", v, c);
        check("t3_first", v, 16384);
        wait_valid("t3_s1", v, c);
        check("t3_second", v, 15360);
        prev = v; mono_ok = 1; clip_seen = 0;
        for (int i = 2; i < 300; i++) begin
            wait_valid("t3_run", v, c);
            if (v > prev) mono_ok = 0;
            if (c) clip_seen = 1;
            prev = v;
        end
        check("t3_monotonic", mono_ok, 1);
        check("t3_no_clip", clip_seen, 0);
        check("t3_settled", (v <= 16 && v >= -16), 1);

        // 4: converge at full scale, then step to zero to force saturation
        @(negedge clk); adc_data = 12'd4095;
        for (int i = 0; i < 200; i++) wait_valid("t4_conv", v, c);
        @(negedge clk); adc_data = 12'd0;
        wait_valid("t4_step", v, c);
        check("t4_sat_value", v, -32768);
        check("t4_sat_clip", c, 1);
        for (int i = 0; i < 200; i++) wait_valid("t4_recover", v, c);
        check("t4_recover_clip", c, 0);
        check("t4_recover_value", (v <= 16 && v >= -16), 1);

        // 5: codes toggling across a tick leave the held mid-scale value
        @(negedge clk); bypass_dc = 1; adc_data = 12'h800;
        repeat (3) wait_valid("t5_pre", v, c);
        check("t5_pre_value", v, 0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); adc_data = (i % 2 == 0) ? 12'h000 : 12'hfff;
        end
        @(negedge clk); adc_data = 12'h800;
        for (int i = 0; i < 3; i++) begin
            wait_valid("t5_post", v, c);
            check("t5_held_value", v, 0);
        end

        // 6: reset one cycle after a tick discards the in-flight sample
        @(negedge clk); rst = 1; adc_data = 12'd3072; bypass_dc = 0;
        @(negedge clk); rst = 0;
        repeat (3) wait_valid("t6_pre", v, c);
        repeat (DIV - 1) @(posedge clk);
        @(negedge clk); rst = 1;
        #1 check("t6_async_out", sample_out, 0);
        check("t6_async_valid", sample_valid, 0);
        check("t6_async_clip", clip, 0);
        repeat (2) @(negedge clk); rst = 0;
        count_to_valid("t6_first", k);
        check("t6_first_latency", k, 9);
        check("t6_restart_first", sample_out, 16384);
        wait_valid("t6_s1", v, c);
        check("t6_restart_second", v, 15360);

        // Randomized codes, hold lengths and bypass toggles
        for (int i = 0; i < 250; i++) begin
            int hold;
            hold = $urandom_range(1, 12);
            adc_data = 12'($urandom);
            if ($urandom_range(0, 7) == 0) bypass_dc = ~bypass_dc;
            repeat (hold) @(negedge clk);
        end
        repeat (3 * DIV) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
